hilo_accumulator: RTL

- Sequential HI/LO result stage directly downstream of the 32x32 multiplier; consumes its 64-bit `product`.
- Commits the product to architectural HI/LO registers by overwrite, multiply-add or multiply-subtract.
- Also supports direct writes to HI and LO.
- MADD/MSUB use a two-cycle split 64-bit adder (low half, then high half) with backpressure via `op_ready`.

---
 rtl/hilo_accumulator.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hilo_accumulator.sv
// HI/LO result stage: commits multiplier products by overwrite, multiply-add or
// multiply-subtract (two-cycle split adder), plus direct HI/LO writes.
module hilo_accumulator #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [2:0]           op,
  input  logic [2*WIDTH-1:0]   product,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     hi,
  output logic [WIDTH-1:0]     lo,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD_LO = 2'd1,
    ST_ADD_HI = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL  = 3'd1;
  localparam logic [2:0] OP_MADD = 3'd2;
  localparam logic [2:0] OP_MSUB = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  // Signed overflow of a two's-complement add, judged from the operand and sum sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t               state_r, state_s;
  logic [WIDTH-1:0]     hi_r, hi_s;
  logic [WIDTH-1:0]     lo_r, lo_s;
  logic [2*WIDTH-1:0]   b_r, b_s;
  logic                 cin_r, cin_s;
  logic                 carry_r, carry_s;
  logic                 ovf_r, ovf_s;
  logic                 done_r, done_s;
  logic                 ready_r, busy_r;
  logic                 accept_s;
  logic [WIDTH:0]       lo_sum_s;
  logic [WIDTH-1:0]     hi_sum_s;

  // Next-state and datapath update for the IDLE / ADD_LO / ADD_HI sequencer.
  always_comb begin
    state_s  = state_r;
    hi_s     = hi_r;
    lo_s     = lo_r;
    b_s      = b_r;
    cin_s    = cin_r;
    carry_s  = carry_r;
    ovf_s    = ovf_r;
    done_s   = 1'b0;
    lo_sum_s = {(WIDTH+1){1'b0}};
    hi_sum_s = {WIDTH{1'b0}};
    accept_s = op_valid && (state_r == ST_IDLE);

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (op)
            OP_MUL: begin
              {hi_s, lo_s} = product;
              ovf_s        = 1'b0;
              done_s       = 1'b1;
            end
            OP_MADD: begin
              b_s     = product;
              cin_s   = 1'b0;
              state_s = ST_ADD_LO;
            end
            // Subtraction adds the one's complement with a carry-in of one.
            OP_MSUB: begin
              b_s     = ~product;
              cin_s   = 1'b1;
              state_s = ST_ADD_LO;
            end
            OP_MTHI: begin
              hi_s   = wdata;
              done_s = 1'b1;
            end
            OP_MTLO: begin
              lo_s   = wdata;
              done_s = 1'b1;
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADD_LO: begin
        lo_sum_s = {1'b0, lo_r} + {1'b0, b_r[WIDTH-1:0]} + {{WIDTH{1'b0}}, cin_r};
        lo_s     = lo_sum_s[WIDTH-1:0];
        carry_s  = lo_sum_s[WIDTH];
        state_s  = ST_ADD_HI;
      end
      ST_ADD_HI: begin
        hi_sum_s = hi_r + b_r[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, carry_r};
        hi_s     = hi_sum_s;
        ovf_s    = ovf_r | add_ovf(hi_r[WIDTH-1], b_r[2*WIDTH-1], hi_sum_s[WIDTH-1]);
        done_s   = 1'b1;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and architectural registers; reset discards any half-finished add.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      b_r     <= {(2*WIDTH){1'b0}};
      cin_r   <= 1'b0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      b_r     <= b_s;
      cin_r   <= cin_s;
      carry_r <= carry_s;
      ovf_r   <= ovf_s;
      done_r  <= done_s;
      ready_r <= (state_s == ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign hi       = hi_r;
  assign lo       = lo_r;
  assign ovf      = ovf_r;
  assign done     = done_r;
  assign op_ready = ready_r;
  assign busy     = busy_r;

endmodule
